load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle load/store engine between the core's execute stage (ALU address, rs2 data, funct3) and data memory.
- Generates the byte enables the datapath currently leaves undriven.
- Aligns store data onto byte lanes, and extracts and sign/zero-extends load data.
- Runs a request/ready handshake with memory, holds the core on stall_o until the access completes, and flags misaligned or illegal accesses and memory timeouts.

Parameters:
DATA_WIDTH, 32, core and memory data width; only 32 supported.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 16, max cycles in BUSY without mem_ready_i before aborting; must be >= 1.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid_i  input  1  core requests a load/store; held with operands until done_o.
is_store_i  input  1  1 = store, 0 = load.
funct3_i  input  3  RV32I width/sign field.
addr_i  input  ADDR_WIDTH  byte address from ALU.
wr_data_i  input  DATA_WIDTH  store data (rs2).
stall_o  output  1  freeze PC/pipeline.
done_o  output  1  one-cycle completion pulse.
load_data_o  output  DATA_WIDTH  extended load result, valid with done_o.
err_o  output  1  with done_o: misaligned, illegal funct3 or timeout.
mem_req_o  output  1  memory request.
mem_we_o  output  1  memory write.
mem_addr_o  output  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00}).
mem_byte_en_o  output  4  byte-lane enables.
mem_wr_data_o  output  DATA_WIDTH  lane-replicated store data.
mem_ready_i  input  1  memory completes the access this cycle; mem_rd_data_i valid.
mem_rd_data_i  input  DATA_WIDTH  read word.

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; all outputs 0; timeout counter 0; captured data 0. Reset in BUSY drops mem_req_o immediately with no done_o.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - mem_req_o=0.
  - stall_o=req_valid_i (combinational).
  - When req_valid_i: register operands and decode.
  - Legal and aligned -> BUSY. Otherwise -> RESP with err_o pending and no memory access.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned accesses: halfword with addr[0]=1; word with addr[1:0]!=0.
- BUSY:
  - mem_req_o=1; mem_we_o, addr, byte_en and wr_data driven from registered operands and stable throughout BUSY.
  - stall_o=1.
  - Counter increments each cycle.
  - mem_ready_i=1 -> capture mem_rd_data_i, go to RESP.
  - Counter reaches TIMEOUT_CYCLES without ready -> RESP with err_o. If ready arrives in the same cycle as expiry, ready wins.
- RESP:
  - Exactly one cycle: done_o=1, stall_o=0, err_o per outcome, mem_req_o=0.
  - load_data_o valid for loads; 0 for stores and errors.
  - Then IDLE.
  - Back-to-back: a new req_valid_i is sampled only in IDLE, so the minimum issue-to-issue gap is 3 cycles at zero wait states.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
  - Loads use the same byte enables.
- Store data: byte {4{wr[7:0]}}; half {2{wr[15:0]}}; word as-is.
- Load data:
  - Shift captured word right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW unmodified.
- mem_req_o is never asserted for an erroring access. Memory sees at most one request per core request.

Decomposition:
- Shared package (riscv_pkg): funct3 width encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the lsu_state_t enum {IDLE, BUSY, RESP}.
- One natural combinational sub-module, lsu_align: funct3, addr[1:0], wr_data and rd_word in; byte_en, lane data, extended load data and misaligned/illegal flag out.
- FSM, counter and registers stay in load_store_unit.

Test Plan:
- Reset mid-BUSY (mem_ready_i held 0, drop rst_n) -> mem_req_o, stall_o and done_o go to 0 asynchronously; after release the FSM is in IDLE and the next request completes normally.
- SB addr=0x1003, wr_data=0x000000A5, ready after 2 wait cycles -> mem_addr_o=0x1000, byte_en=4'b1000, wr_data=0xA5A5A5A5, mem_we_o=1; stall_o high 4 cycles, then done_o=1, err_o=0.
- LB addr=0x2002, mem_rd_data_i=0x12F45678, zero wait -> load_data_o=0xFFFFFFF4; repeat as LBU -> 0x000000F4; LHU addr=0x2002 -> 0x000012F4.
- LW addr=0x3001 -> no mem_req_o ever; next cycle done_o=1, err_o=1, load_data_o=0. SH addr=0x3003 gives the same result. funct3=3'b011 load gives the same result.
- LW addr=0x4000 with mem_ready_i never asserted, TIMEOUT_CYCLES=16 -> mem_req_o high exactly 16 cycles, then done_o=1, err_o=1.
- SW 0x5000 then LW 0x5000 back-to-back against a zero-wait memory model -> load returns the stored word; byte_en=4'b1111 for both; done_o pulses are 3 cycles apart.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit.
//   F3_*        : RV32I funct3 width/sign encodings for loads and stores
//   lsu_state_t : load/store unit sequencing states
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
// Ports:
//   funct3_i   width/sign field
//   is_store_i 1 = store (BU/HU encodings are illegal for stores)
//   addr_lo_i  byte offset within the word
//   wr_data_i  raw store data (rs2)
//   rd_word_i  word read from memory
//   byte_en_o  byte-lane enables
//   wr_lane_o  store data replicated onto the lanes
//   ld_data_o  shifted and sign/zero-extended load data
//   bad_o      access is misaligned or funct3 is illegal
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic        is_store_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wr_data_i,
   input  logic [31:0] rd_word_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wr_lane_o,
   output logic [31:0] ld_data_o,
   output logic        bad_o
);

   logic [31:0] shifted;

   assign shifted = rd_word_i >> {addr_lo_i, 3'b000};

   always_comb begin
      byte_en_o = 4'b0000;
      wr_lane_o = wr_data_i;
      ld_data_o = '0;
      bad_o     = 1'b0;
      case (funct3_i)
         F3_B, F3_BU: begin
            byte_en_o = 4'b0001 << addr_lo_i;
            wr_lane_o = {4{wr_data_i[7:0]}};
            ld_data_o = (funct3_i == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                           : {24'b0, shifted[7:0]};
            bad_o     = is_store_i && (funct3_i == F3_BU);
         end
         F3_H, F3_HU: begin
            byte_en_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            wr_lane_o = {2{wr_data_i[15:0]}};
            ld_data_o = (funct3_i == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                           : {16'b0, shifted[15:0]};
            bad_o     = addr_lo_i[0] || (is_store_i && (funct3_i == F3_HU));
         end
         F3_W: begin
            byte_en_o = 4'b1111;
            ld_data_o = shifted;
            bad_o     = (addr_lo_i != 2'b00);
         end
         default: bad_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine between the execute stage and data memory.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_valid_i, is_store_i,
//   funct3_i, addr_i, wr_data_i  core request, held until done_o
//   stall_o, done_o, err_o,
//   load_data_o                  core response
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_byte_en_o,
//   mem_wr_data_o                memory request (driven only while BUSY)
//   mem_ready_i, mem_rd_data_i   memory completion
//
// state | meaning
// IDLE  | waiting for req_valid_i; decode and capture operands
// BUSY  | request on memory bus, waiting for mem_ready_i or timeout
// RESP  | one-cycle done_o pulse with err_o / load data
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   input  logic                  is_store_i,
   input  logic [2:0]            funct3_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  stall_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] load_data_o,
   output logic                  err_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]            mem_byte_en_o,
   output logic [DATA_WIDTH-1:0] mem_wr_data_o,
   input  logic                  mem_ready_i,
   input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  store_q, store_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0] rd_word_q, rd_word_d;
   logic                  err_q, err_d;

   // In IDLE the aligner decodes the live request so legality is known
   // before capture; afterwards it works from the registered operands.
   logic                  sel_idle;
   logic [2:0]            al_funct3;
   logic                  al_store;
   logic [1:0]            al_addr_lo;
   logic [DATA_WIDTH-1:0] al_wr_data;
   logic [3:0]            al_byte_en;
   logic [DATA_WIDTH-1:0] al_wr_lane;
   logic [DATA_WIDTH-1:0] al_ld_data;
   logic                  al_bad;

   assign sel_idle   = (state_q == IDLE);
   assign al_funct3  = sel_idle ? funct3_i    : funct3_q;
   assign al_store   = sel_idle ? is_store_i  : store_q;
   assign al_addr_lo = sel_idle ? addr_i[1:0] : addr_q[1:0];
   assign al_wr_data = sel_idle ? wr_data_i   : wr_data_q;

   lsu_align u_align (
      .funct3_i   (al_funct3),
      .is_store_i (al_store),
      .addr_lo_i  (al_addr_lo),
      .wr_data_i  (al_wr_data),
      .rd_word_i  (rd_word_q),
      .byte_en_o  (al_byte_en),
      .wr_lane_o  (al_wr_lane),
      .ld_data_o  (al_ld_data),
      .bad_o      (al_bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         store_q   <= 1'b0;
         funct3_q  <= '0;
         addr_q    <= '0;
         wr_data_q <= '0;
         rd_word_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         store_q   <= store_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         rd_word_q <= rd_word_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      store_d     = store_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wr_data_d   = wr_data_q;
      rd_word_d   = rd_word_q;
      err_d       = err_q;
      stall_o     = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      mem_req_o   = 1'b0;
      load_data_o = '0;
      case (state_q)
         IDLE: begin
            stall_o = req_valid_i;
            if (req_valid_i) begin
               store_d   = is_store_i;
               funct3_d  = funct3_i;
               addr_d    = addr_i;
               wr_data_d = wr_data_i;
               rd_word_d = '0;
               err_d     = al_bad;
               cnt_d     = '0;
               state_d   = al_bad ? RESP : BUSY;
            end
         end
         BUSY: begin
            stall_o   = 1'b1;
            mem_req_o = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            // ready takes priority over a timeout expiring in the same cycle
            if (mem_ready_i) begin
               rd_word_d = mem_rd_data_i;
               err_d     = 1'b0;
               cnt_d     = '0;
               state_d   = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            done_o      = 1'b1;
            err_o       = err_q;
            load_data_o = (!store_q && !err_q) ? al_ld_data : '0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_we_o      = mem_req_o && store_q;
   assign mem_addr_o    = mem_req_o ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_byte_en_o = mem_req_o ? al_byte_en : 4'b0000;
   assign mem_wr_data_o = mem_req_o ? al_wr_lane : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small
// byte-enable-aware memory model whose wait states are programmable.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid_i;
   logic        is_store_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wr_data_i;
   logic        stall_o;
   logic        done_o;
   logic [31:0] load_data_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_byte_en_o;
   logic [31:0] mem_wr_data_o;
   logic        mem_ready_i;
   logic [31:0] mem_rd_data_i;

   int n_chk  = 0;
   int n_fail = 0;

   load_store_unit #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid_i),
      .is_store_i    (is_store_i),
      .funct3_i      (funct3_i),
      .addr_i        (addr_i),
      .wr_data_i     (wr_data_i),
      .stall_o       (stall_o),
      .done_o        (done_o),
      .load_data_o   (load_data_o),
      .err_o         (err_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_byte_en_o (mem_byte_en_o),
      .mem_wr_data_o (mem_wr_data_o),
      .mem_ready_i   (mem_ready_i),
      .mem_rd_data_i (mem_rd_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: 16 words indexed by addr[15:12]
   logic [31:0] mem [16];
   int          wcnt;
   int          wait_cfg;

   assign mem_ready_i   = mem_req_o && (wcnt == wait_cfg);
   assign mem_rd_data_i = mem[mem_addr_o[15:12]];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= 0;
         for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
         mem[2] <= 32'h12F4_5678;
      end else begin
         if (mem_req_o && !mem_ready_i) wcnt <= wcnt + 1;
         else                           wcnt <= 0;
         if (mem_req_o && mem_ready_i && mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_byte_en_o[b])
                  mem[mem_addr_o[15:12]][b*8 +: 8] <= mem_wr_data_o[b*8 +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // results of the most recent request
   int          r_stall, r_req, r_cyc;
   logic        r_err, r_we;
   logic [31:0] r_ld, r_addr, r_wd;
   logic [3:0]  r_be;
   time         r_tdone;

   // Called at a negedge with the unit in IDLE. Holds the request until
   // done_o, then releases req_valid_i unless hold is set.
   task automatic run_req(input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic hold);
      logic seen;
      seen       = 1'b0;
      r_stall    = 0;
      r_req      = 0;
      r_cyc      = 0;
      r_err      = 1'b0;
      r_we       = 1'b0;
      r_ld       = '0;
      r_addr     = '0;
      r_wd       = '0;
      r_be       = '0;
      is_store_i = st;
      funct3_i   = f3;
      addr_i     = addr;
      wr_data_i  = wd;
      req_valid_i = 1'b1;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (stall_o) r_stall++;
         if (mem_req_o) begin
            if (r_req == 0) begin
               r_we   = mem_we_o;
               r_addr = mem_addr_o;
               r_be   = mem_byte_en_o;
               r_wd   = mem_wr_data_o;
            end
            r_req++;
         end
         if (done_o) begin
            seen    = 1'b1;
            r_cyc   = i;
            r_err   = err_o;
            r_ld    = load_data_o;
            r_tdone = $time;
            break;
         end
         @(negedge clk);
      end
      check("done_seen", {31'b0, seen}, 32'd1);
      if (!hold) req_valid_i = 1'b0;
      @(negedge clk);
   endtask

   time t_sw;

   initial begin
      rst_n       = 1'b0;
      req_valid_i = 1'b0;
      is_store_i  = 1'b0;
      funct3_i    = 3'b000;
      addr_i      = '0;
      wr_data_i   = '0;
      wait_cfg    = 0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
      check("rst_stall",   {31'b0, stall_o},   32'd0);
      check("rst_done",    {31'b0, done_o},    32'd0);
      check("rst_err",     {31'b0, err_o},     32'd0);
      check("rst_ld",      load_data_o,        32'd0);
      check("rst_addr",    mem_addr_o,         32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset while BUSY
      wait_cfg    = 1000;
      is_store_i  = 1'b0;
      funct3_i    = 3'b010;
      addr_i      = 32'h4000;
      req_valid_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("busy_before_rst", {31'b0, mem_req_o}, 32'd1);
      #2;
      req_valid_i = 1'b0;
      rst_n       = 1'b0;
      #1;
      check("rst_busy_mem_req", {31'b0, mem_req_o}, 32'd0);
      check("rst_busy_stall",   {31'b0, stall_o},   32'd0);
      check("rst_busy_done",    {31'b0, done_o},    32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      wait_cfg = 0;
      @(negedge clk);
      run_req(1'b0, 3'b010, 32'h2000, 32'h0, 1'b0);
      check("post_rst_lw_ld",  r_ld,             32'h12F4_5678);
      check("post_rst_lw_err", {31'b0, r_err},   32'd0);

      // SB with two wait cycles
      wait_cfg = 2;
      run_req(1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 1'b0);
      check("sb_addr",  r_addr,              32'h1000);
      check("sb_be",    {28'b0, r_be},       32'h8);
      check("sb_wd",    r_wd,                32'hA5A5_A5A5);
      check("sb_we",    {31'b0, r_we},       32'd1);
      check("sb_stall", r_stall,             32'd4);
      check("sb_err",   {31'b0, r_err},      32'd0);
      check("sb_mem",   mem[1],              32'hA500_0000);

      // loads, zero wait
      wait_cfg = 0;
      run_req(1'b0, 3'b000, 32'h2002, 32'h0, 1'b0);
      check("lb_ld", r_ld,         32'hFFFF_FFF4);
      check("lb_be", {28'b0, r_be}, 32'h4);
      run_req(1'b0, 3'b100, 32'h2002, 32'h0, 1'b0);
      check("lbu_ld", r_ld, 32'h0000_00F4);
      run_req(1'b0, 3'b101, 32'h2002, 32'h0, 1'b0);
      check("lhu_ld", r_ld,          32'h0000_12F4);
      check("lhu_be", {28'b0, r_be}, 32'hC);
      check("lhu_we", {31'b0, r_we}, 32'd0);

      // erroring accesses: no memory request, done next cycle
      run_req(1'b0, 3'b010, 32'h3001, 32'h0, 1'b0);
      check("lw_mis_req", r_req,          32'd0);
      check("lw_mis_err", {31'b0, r_err}, 32'd1);
      check("lw_mis_ld",  r_ld,           32'd0);
      check("lw_mis_cyc", r_cyc,          32'd1);
      run_req(1'b1, 3'b001, 32'h3003, 32'h1234_5678, 1'b0);
      check("sh_mis_req", r_req,          32'd0);
      check("sh_mis_err", {31'b0, r_err}, 32'd1);
      check("sh_mis_cyc", r_cyc,          32'd1);
      check("sh_mis_mem", mem[3],         32'd0);
      run_req(1'b0, 3'b011, 32'h3000, 32'h0, 1'b0);
      check("ill_req", r_req,          32'd0);
      check("ill_err", {31'b0, r_err}, 32'd1);
      check("ill_ld",  r_ld,           32'd0);

      // timeout
      wait_cfg = 1000;
      run_req(1'b0, 3'b010, 32'h4000, 32'h0, 1'b0);
      check("to_req", r_req,          32'd16);
      check("to_err", {31'b0, r_err}, 32'd1);
      check("to_ld",  r_ld,           32'd0);

      // back-to-back SW then LW
      wait_cfg = 0;
      run_req(1'b1, 3'b010, 32'h5000, 32'hDEAD_BEEF, 1'b1);
      t_sw = r_tdone;
      check("sw_be",  {28'b0, r_be},  32'hF);
      check("sw_err", {31'b0, r_err}, 32'd0);
      check("sw_ld",  r_ld,           32'd0);
      run_req(1'b0, 3'b010, 32'h5000, 32'h0, 1'b0);
      check("lw_ld",  r_ld,           32'hDEAD_BEEF);
      check("lw_be",  {28'b0, r_be},  32'hF);
      check("b2b_gap", 32'((r_tdone - t_sw) / 10), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
